pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 127 ++++++++++++
 tb/tb_pipe_addsub.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: WIDTH split into STAGES carry-registered slices, global-stall
// valid/ready handshake. Define PIPE_ADDSUB_SAT_EN to add the per-op saturation input sat.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             sub,
`ifdef PIPE_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage state: operands (b already inverted for sub), partial sum, slice carry.
  logic [STAGES-1:0] v_q, v_d, c_q, c_d;
  logic [STAGES-1:0] src_v, src_c;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [SW:0]       slice_sum [STAGES];
`ifdef PIPE_ADDSUB_SAT_EN
  logic [STAGES-1:0] sat_q, sat_d, src_sat;
`endif

  logic [WIDTH-1:0] res;
  logic             fin_ovf;

  assign in_ready = !v_q[LAST] || out_ready;

  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = data1;
    src_b[0] = sub ? ~data2 : data2;
    src_s[0] = '0;
    src_c[0] = sub;
`ifdef PIPE_ADDSUB_SAT_EN
    src_sat[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
      src_sat[k] = sat_q[k-1];
`endif
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
                     + {{SW{1'b0}}, src_c[k]};
      v_d[k] = src_v[k];
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
      s_d[k] = src_s[k];
      s_d[k][k*SW +: SW] = slice_sum[k][SW-1:0];
      c_d[k] = slice_sum[k][SW];
`ifdef PIPE_ADDSUB_SAT_EN
      sat_d[k] = src_sat[k];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
`ifdef PIPE_ADDSUB_SAT_EN
      sat_q <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (in_ready) begin
      v_q <= v_d;
      c_q <= c_d;
`ifdef PIPE_ADDSUB_SAT_EN
      sat_q <= sat_d;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  // Outputs are forced to zero whenever the last slot is empty, including during reset.
  always_comb begin
    fin_ovf = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
              && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    res = s_q[LAST];
`ifdef PIPE_ADDSUB_SAT_EN
    if (sat_q[LAST] && fin_ovf) begin
      res = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    out_valid  = v_q[LAST];
    add_result = v_q[LAST] ? res : '0;
    carry_out  = v_q[LAST] && c_q[LAST];
    overflow   = v_q[LAST] && fin_ovf;
    zero       = v_q[LAST] && (res == '0);
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed 32-bit/2-stage vectors plus 24-bit instances
// with STAGES 1, 3, 4 checked against a full-width reference model.
module tb_pipe_addsub;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        lat;
    logic [31:0] acc;
  } exp_t;

  logic        clk, rst;
  logic        in_valid, in_ready, sub, sat_in, out_valid, out_ready;
  logic [31:0] data1, data2, add_result;
  logic        carry_out, overflow, zero;
  logic        rand_ready, aux_end;
  logic        x_valid, x_sub;
  logic [23:0] x_d1, x_d2;
  int unsigned cyc;
  int          checks, errors;
  exp_t        sb[$];

  pipe_addsub #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .sub(sub),
`ifdef PIPE_ADDSUB_SAT_EN
    .sat(sat_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .add_result(add_result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish before 300000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endtask

  function automatic logic [26:0] model24(input logic [23:0] a, input logic [23:0] b0,
                                          input logic s);
    logic [23:0] b, r;
    logic [24:0] f;
    logic        o;
    b = s ? ~b0 : b0;
    f = {1'b0, a} + {1'b0, b} + {24'd0, s};
    r = f[23:0];
    o = (a[23] == b[23]) && (r[23] != a[23]);
    return {r, f[24], o, (r == 24'd0)};
  endfunction

  // Drive one op and wait until it is accepted; expected result enters the scoreboard then.
  task automatic issue(input logic [31:0] d1, input logic [31:0] d2, input logic s,
                       input logic st, input logic [31:0] r, input logic c, input logic o,
                       input logic z);
    bit done;
    done = 0;
    in_valid = 1'b1;
    data1 = d1;
    data2 = d2;
    sub = s;
    sat_in = st;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        sb.push_back('{res: r, c: c, o: o, z: z, lat: !rand_ready, acc: cyc});
        done = 1;
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready low 100 cycles, required accept");
    end
  endtask

  // Garbage operands with in_valid low must never surface.
  task automatic bubble();
    in_valid = 1'b0;
    data1 = $urandom;
    data2 = $urandom;
    sub = 1'($urandom_range(0, 1));
    sat_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(posedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Main monitor: pops on every output transfer, checks stall stability and in_ready.
  initial begin
    logic        stalled;
    logic [34:0] prev, cur;
    exp_t        e;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        cur = {add_result, carry_out, overflow, zero};
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (stalled) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", 64'(cur), 64'(prev));
        end
        stalled = out_valid && !out_ready;
        prev = cur;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h required no output", cur);
          end else begin
            e = sb.pop_front();
            chk("result", 64'(cur), 64'({e.res, e.c, e.o, e.z}));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_aux
    localparam int unsigned S = (gi == 0) ? 1 : gi + 2;
    logic        ir, ov, co, of, zf;
    logic [23:0] r;
    logic [26:0] q[$];
    int unsigned qa[$];

    pipe_addsub #(.WIDTH(24), .STAGES(S)) u_aux (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(ir),
      .data1(x_d1), .data2(x_d2), .sub(x_sub),
`ifdef PIPE_ADDSUB_SAT_EN
      .sat(1'b0),
`endif
      .out_valid(ov), .out_ready(1'b1), .add_result(r),
      .carry_out(co), .overflow(of), .zero(zf)
    );

    initial forever begin
      @(negedge clk);
      #1;
      if (!rst && x_valid && ir) begin
        q.push_back(model24(x_d1, x_d2, x_sub));
        qa.push_back(cyc);
      end
    end

    initial begin
      logic [26:0] e;
      int unsigned a;
      forever begin
        @(negedge clk);
        if (!rst && ov) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL aux%0d_unexpected: got %h required no output", S, r);
          end else begin
            e = q.pop_front();
            a = qa.pop_front();
            chk($sformatf("aux%0d_result", S), 64'({r, co, of, zf}), 64'(e));
            chk($sformatf("aux%0d_latency", S), 64'(cyc - a), 64'(S));
          end
        end
      end
    end

    initial begin
      @(posedge aux_end);
      chk($sformatf("aux%0d_drain", S), 64'(q.size()), 64'd0);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    data1 = '0;
    data2 = '0;
    sub = 1'b0;
    sat_in = 1'b0;
    out_ready = 1'b1;
    rand_ready = 1'b0;
    aux_end = 1'b0;
    x_valid = 1'b0;
    x_d1 = '0;
    x_d2 = '0;
    x_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_add_result", 64'(add_result), 64'd0);
    chk("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, out_ready held high (latency checked).
    issue(32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
    issue(32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0);
    issue(32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    issue(32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_ADDSUB_SAT_EN
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif
    bubble();
    drain();

    // Stream of 8 with random backpressure and bubbles.
    rand_ready = 1'b1;
    issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    issue(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    bubble();
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    bubble();
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    issue(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    issue(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();

    // Asynchronous reset mid-cycle with two ops in flight.
    out_ready = 1'b0;
    issue(32'h11, 32'h22, 1'b0, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0);
    issue(32'h44, 32'h55, 1'b0, 1'b0, 32'h99, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_outputs", 64'({add_result, carry_out, overflow, zero}), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #3;
    chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_release_in_ready", 64'(in_ready), 64'd1);
    issue(32'h100, 32'h200, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0);
    drain();

    // 24-bit instances, random operands, no backpressure.
    for (int n = 0; n < 40; n++) begin
      x_valid = ($urandom_range(0, 3) != 0);
      x_d1 = 24'($urandom);
      x_d2 = 24'($urandom);
      x_sub = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    x_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    aux_end = 1'b1;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
